decode_offset_buffer: RTL and testbench

Two-entry buffered decode stage between instruction fetch and the sign extender. It accepts fetched 16-bit instruction words with their PC over a valid/ready handshake. For each word it extracts the raw offset field, the field's MSB index and the shift-first flag, and holds up to two decoded entries in order. The head entry drives the sign extender's `in`, `msb_num` and `shift_first` inputs and the execute stage's handshake.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/offset_field_decode.sv | 36 +++
 rtl/decode_offset_buffer.sv | 88 ++++++++
 tb/tb_decode_offset_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: instruction classes, opcode prefixes and the offset-field
// MSB positions used by the decode stage and the sign extender.
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    CLASS_BL    = 2'd0,
    CLASS_BCC   = 2'd1,
    CLASS_LDST  = 2'd2,
    CLASS_OTHER = 2'd3
  } instr_class_t;

  localparam logic [2:0] OP_BL  = 3'b000;
  localparam logic [2:0] OP_BCC = 3'b001;

  localparam logic [3:0] BL_MSB       = 4'd12;
  localparam logic [3:0] BCC_MSB      = 4'd9;
  localparam logic [3:0] LDST_MSB     = 4'd6;
  localparam logic [3:0] NO_FIELD_MSB = 4'd15;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm_raw;
    logic [3:0]        msb_num;
    logic              shift_first;
    instr_class_t      instr_class;
  } dec_entry_t;

endpackage

// File: rtl/offset_field_decode.sv
// Combinational extraction of the branch/load-store offset field, its MSB index and
// whether the offset counts halfwords (shift left by 1 before use).
module offset_field_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm_raw,
  output logic [3:0]        msb_num,
  output logic              shift_first,
  output instr_class_t      instr_class
);

  always_comb begin
    imm_raw     = '0;
    msb_num     = NO_FIELD_MSB;
    shift_first = 1'b0;
    instr_class = CLASS_OTHER;
    if (instr[15:13] == OP_BL) begin
      imm_raw     = {3'b0, instr[12:0]};
      msb_num     = BL_MSB;
      shift_first = 1'b1;
      instr_class = CLASS_BL;
    end else if (instr[15:13] == OP_BCC) begin
      imm_raw     = {6'b0, instr[9:0]};
      msb_num     = BCC_MSB;
      shift_first = 1'b1;
      instr_class = CLASS_BCC;
    end else if (instr[15]) begin
      // Both 10x and 11x prefixes are loads/stores with a 7-bit byte offset.
      imm_raw     = {9'b0, instr[13:7]};
      msb_num     = LDST_MSB;
      instr_class = CLASS_LDST;
    end
  end

endmodule

// File: rtl/decode_offset_buffer.sv
// Two-entry FIFO between fetch and the sign extender; words are decoded on entry so the
// head outputs come straight from registered storage.
module decode_offset_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] imm_raw,
  output logic [3:0]        msb_num,
  output logic              shift_first,
  output logic [1:0]        instr_class
);

  dec_entry_t   buf_mem [2];
  dec_entry_t   dec_new;
  dec_entry_t   head;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  logic [DATA_W-1:0] dec_imm;
  logic [3:0]        dec_msb;
  logic              dec_shift;
  instr_class_t      dec_class;

  offset_field_decode u_decode (
    .instr       (in_instr),
    .imm_raw     (dec_imm),
    .msb_num     (dec_msb),
    .shift_first (dec_shift),
    .instr_class (dec_class)
  );

  assign dec_new = '{instr: in_instr, pc: in_pc, imm_raw: dec_imm, msb_num: dec_msb,
                     shift_first: dec_shift, instr_class: dec_class};

  // Ready depends on state only, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) buf_mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= dec_new;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head        = buf_mem[rd_ptr];
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign imm_raw     = head.imm_raw;
  assign msb_num     = head.msb_num;
  assign shift_first = head.shift_first;
  assign instr_class = head.instr_class;

endmodule

// File: tb/tb_decode_offset_buffer.sv
// Directed bench for decode_offset_buffer: reset, class decode, backpressure, push/pop
// overlap with pointer wrap, flush and mid-stream reset.
module tb_decode_offset_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] imm_raw;
  logic [3:0]  msb_num;
  logic        shift_first;
  logic [1:0]  instr_class;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_offset_buffer #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .imm_raw     (imm_raw),
    .msb_num     (msb_num),
    .shift_first (shift_first),
    .instr_class (instr_class)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                          input logic [15:0] imm, input logic [3:0] msb,
                          input logic shf, input logic [1:0] cls);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_instr"}, 32'(out_instr), 32'(instr));
    chk({tag, ".out_pc"}, 32'(out_pc), 32'(pc));
    chk({tag, ".imm_raw"}, 32'(imm_raw), 32'(imm));
    chk({tag, ".msb_num"}, 32'(msb_num), 32'(msb));
    chk({tag, ".shift_first"}, 32'(shift_first), 32'(shf));
    chk({tag, ".instr_class"}, 32'(instr_class), 32'(cls));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".zero_data"},
        {out_instr, out_pc} | 32'(imm_raw) | 32'(msb_num) | 32'(shift_first) | 32'(instr_class),
        32'd0);
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  logic [15:0] dec_instr [4];
  logic [15:0] dec_imm   [4];
  logic [3:0]  dec_msb   [4];
  logic        dec_shf   [4];
  logic [1:0]  dec_cls   [4];

  initial begin
    dec_instr = '{16'h1FFF, 16'h23FF, 16'h8F80, 16'h4C00};
    dec_imm   = '{16'h1FFF, 16'h03FF, 16'h001F, 16'h0000};
    dec_msb   = '{4'd12, 4'd9, 4'd6, 4'd15};
    dec_shf   = '{1'b1, 1'b1, 1'b0, 1'b0};
    dec_cls   = '{2'd0, 2'd1, 2'd2, 2'd3};

    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    step(); step();
    chk_zero("reset");
    reset_n = 1'b1;

    // Class decode, one word at a time.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dec_instr[i], 16'h0010 + 16'(2 * i));
      step();
      drive(1'b0, 16'h0, 16'h0);
      chk_head($sformatf("decode%0d", i), dec_instr[i], 16'h0010 + 16'(2 * i),
               dec_imm[i], dec_msb[i], dec_shf[i], dec_cls[i]);
      step();
      chk($sformatf("decode%0d.drained", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: fill with out_ready low, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 16'h1001, 16'h0100); step();
    drive(1'b1, 16'h2005, 16'h0102); step();
    drive(1'b0, 16'h0, 16'h0);
    chk("bp.in_ready_full", 32'(in_ready), 32'd0);
    chk_head("bp.head0", 16'h1001, 16'h0100, 16'h1001, 4'd12, 1'b1, 2'd0);
    step();
    chk_head("bp.hold", 16'h1001, 16'h0100, 16'h1001, 4'd12, 1'b1, 2'd0);
    out_ready = 1'b1;
    step();
    chk_head("bp.head1", 16'h2005, 16'h0102, 16'h0005, 4'd9, 1'b1, 2'd1);
    chk("bp.in_ready_one", 32'(in_ready), 32'd1);
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop with one entry held.
    out_ready = 1'b0;
    drive(1'b1, 16'h8080, 16'h0200); step();
    chk_head("pp.first", 16'h8080, 16'h0200, 16'h0001, 4'd6, 1'b0, 2'd2);
    out_ready = 1'b1;
    drive(1'b1, 16'h0ABC, 16'h0202); step();
    chk("pp.in_ready", 32'(in_ready), 32'd1);
    chk_head("pp.second", 16'h0ABC, 16'h0202, 16'h0ABC, 4'd12, 1'b1, 2'd0);

    // Six-word stream, one per cycle, crossing the pointer wrap several times.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 16'h0300 + 16'(2 * i));
      step();
      chk_head($sformatf("stream%0d", i), 16'h0010 + 16'(i), 16'h0300 + 16'(2 * i),
               16'h0010 + 16'(i), 4'd12, 1'b1, 2'd0);
      chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("stream.drained", 32'(out_valid), 32'd0);

    // Flush while full with a word offered.
    out_ready = 1'b0;
    drive(1'b1, 16'h2001, 16'h0400); step();
    drive(1'b1, 16'h2002, 16'h0402); step();
    chk("flush.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 16'h2003, 16'h0404); step();
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    // Flush on an empty buffer drops an accepted-looking push.
    drive(1'b1, 16'h2004, 16'h0406); step();
    chk("flush.push_dropped", 32'(out_valid), 32'd0);
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0); step();
    chk("flush.stays_empty", 32'(out_valid), 32'd0);
    drive(1'b1, 16'h2007, 16'h0410); step();
    drive(1'b0, 16'h0, 16'h0);
    chk_head("flush.next", 16'h2007, 16'h0410, 16'h0007, 4'd9, 1'b1, 2'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Mid-stream reset with two entries held.
    drive(1'b1, 16'h1234, 16'h0500); step();
    drive(1'b1, 16'h8F80, 16'h0502); step();
    drive(1'b0, 16'h0, 16'h0);
    chk("rst.full", 32'(in_ready), 32'd0);
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    chk_zero("rst.mid");
    drive(1'b1, 16'hC100, 16'h0600); step();
    drive(1'b0, 16'h0, 16'h0);
    chk_head("rst.next", 16'hC100, 16'h0600, 16'h0002, 4'd6, 1'b0, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
